// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline stall/flush sequencer
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } pipe_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter with asynchronous active-low reset
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - stall/flush sequencer for a 5-stage pipeline
// Merges load-use, branch redirect and data-memory wait into per-stage controls.
module pipeline_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN_CNT    = 32,
    parameter int MEM_TIMEOUT = 255,
    parameter int TMR_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4:0]          id_rs1,
    input  logic [4:0]          id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [4:0]          ex_rd,
    input  logic                ex_mem_read,
    input  logic                ex_branch_taken,
    input  logic                mem_dreq,
    input  logic                mem_dready,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                id_ex_write,
    output logic                ex_mem_write,
    output logic                id_ex_bubble,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic                mem_wb_bubble,
    output logic                timeout_err,
    output logic [XLEN_CNT-1:0] stall_cycles,
    output logic [XLEN_CNT-1:0] flush_cycles
);

    localparam logic [TMR_W-1:0] TMO = TMR_W'(MEM_TIMEOUT);

    pipe_state_t      state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt, timer_inc;
    logic             luse, mwait, run_eval, freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        state_nxt     = state;
        timer_nxt     = timer;
        timer_inc     = timer + TMR_W'(1);
        run_eval      = 1'b0;
        freeze        = 1'b0;
        mwait         = mem_dreq & ~mem_dready;
        luse          = ex_mem_read && (ex_rd != REG_X0) &&
                        ((id_use_rs1 && (ex_rd == id_rs1)) ||
                         (id_use_rs2 && (ex_rd == id_rs2)));

        case (state)
            RUN: run_eval = 1'b1;
            MEM_WAIT: begin
                if (mem_dready) begin
                    run_eval  = 1'b1;
                    state_nxt = RUN;
                    timer_nxt = '0;
                end else begin
                    freeze    = 1'b1;
                    timer_nxt = timer_inc;
                    if (timer_inc >= TMO) begin
                        state_nxt = TIMEOUT;
                    end
                end
            end
            TIMEOUT: freeze = 1'b1;
            default: state_nxt = RUN;
        endcase

        // A flushed ID instruction cannot hazard, so branch outranks load-use.
        if (run_eval) begin
            if (mwait) begin
                freeze    = 1'b1;
                timer_nxt = TMR_W'(1);
                state_nxt = (TMO <= TMR_W'(1)) ? TIMEOUT : MEM_WAIT;
            end else if (ex_branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (luse) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
        end

        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end

        // Outputs must fall back to idle the instant reset asserts.
        if (!rst_n) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            id_ex_write   = 1'b1;
            ex_mem_write  = 1'b1;
            id_ex_bubble  = 1'b0;
            if_id_flush   = 1'b0;
            id_ex_flush   = 1'b0;
            mem_wb_bubble = 1'b0;
        end
    end

    assign timeout_err = (state == TIMEOUT);

    sat_counter #(.W(XLEN_CNT)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(XLEN_CNT)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (if_id_flush),
        .count (flush_cycles)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    localparam int CW  = 4;
    localparam int TMO = 4;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       br;
        logic       dreq;
        logic       drdy;
    } stim_t;

    typedef struct packed {
        logic          pc;
        logic          ifid;
        logic          idex;
        logic          exmem;
        logic          bub;
        logic          ifl;
        logic          exfl;
        logic          mwb;
        logic          terr;
        logic [CW-1:0] st;
        logic [CW-1:0] fl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic          mem_dreq, mem_dready;
    logic          pc_write, if_id_write, id_ex_write, ex_mem_write;
    logic          id_ex_bubble, if_id_flush, id_ex_flush, mem_wb_bubble, timeout_err;
    logic [CW-1:0] stall_cycles, flush_cycles;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    bit   m_wait, m_to;
    int   m_wcnt, m_st, m_fl;
    int   max_cnt  = (1 << CW) - 1;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .XLEN_CNT    (CW),
        .MEM_TIMEOUT (TMO),
        .TMR_W       (8)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_use_rs1      (id_use_rs1),
        .id_use_rs2      (id_use_rs2),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_dreq        (mem_dreq),
        .mem_dready      (mem_dready),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_write     (id_ex_write),
        .ex_mem_write    (ex_mem_write),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .timeout_err     (timeout_err),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles)
    );

    // Reference: count consecutive frozen wait cycles; expected values are pre-update counts.
    task automatic model(input stim_t s, output exp_t e);
        bit haz, frz;
        e       = '0;
        e.pc    = 1'b1;
        e.ifid  = 1'b1;
        e.idex  = 1'b1;
        e.exmem = 1'b1;
        e.st    = CW'(m_st);
        e.fl    = CW'(m_fl);
        e.terr  = m_to;
        if (!s.rst) begin
            m_wait = 0; m_to = 0; m_wcnt = 0; m_st = 0; m_fl = 0;
            e.st = '0; e.fl = '0; e.terr = 1'b0;
            return;
        end
        haz = s.mr && (s.rd != 0) && ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
        frz = 0;
        if (m_to) begin
            frz = 1;
        end else if (m_wait && !s.drdy) begin
            frz = 1;
            m_wcnt++;
            if (m_wcnt >= TMO) m_to = 1;
        end else if (s.dreq && !s.drdy) begin
            frz    = 1;
            m_wait = 1;
            m_wcnt = 1;
            if (m_wcnt >= TMO) m_to = 1;
        end else begin
            m_wait = 0;
            m_wcnt = 0;
            if (s.br) begin
                e.ifl  = 1'b1;
                e.exfl = 1'b1;
            end else if (haz) begin
                e.pc   = 1'b0;
                e.ifid = 1'b0;
                e.bub  = 1'b1;
            end
        end
        if (frz) begin
            e.pc = 1'b0; e.ifid = 1'b0; e.idex = 1'b0; e.exmem = 1'b0; e.mwb = 1'b1;
        end
        if (!e.pc && m_st < max_cnt) m_st++;
        if (e.ifl && m_fl < max_cnt) m_fl++;
    endtask

    function automatic stim_t idle();
        stim_t s;
        s     = '0;
        s.rst = 1'b1;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n           = s.rst;
        id_rs1          = s.rs1;
        id_rs2          = s.rs2;
        id_use_rs1      = s.u1;
        id_use_rs2      = s.u2;
        ex_rd           = s.rd;
        ex_mem_read     = s.mr;
        ex_branch_taken = s.br;
        mem_dreq        = s.dreq;
        mem_dready      = s.drdy;
        model(s, e);
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e, got;
        if (q.size() > 0) begin
            e   = q.pop_front();
            got = {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
                   if_id_flush, id_ex_flush, mem_wb_bubble, timeout_err,
                   stall_cycles, flush_cycles};
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL ctrl_cycle%0d got=%b required=%b (pc,ifid,idex,exmem,bub,ifl,exfl,mwb,terr,stall,flush)",
                         cyc, got, e);
            end
            cyc++;
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        {id_rs1, id_rs2, ex_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_dreq, mem_dready} = '0;

        s = idle(); s.rst = 1'b0;
        drive(s); drive(s);
        drive(idle());

        s = idle(); s.mr = 1; s.rd = 5; s.rs2 = 5; s.u2 = 1;
        drive(s);
        drive(idle()); drive(idle());

        s = idle(); s.mr = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
        drive(s);
        s = idle(); s.mr = 1; s.rd = 7; s.rs2 = 7; s.u2 = 0; s.rs1 = 3; s.u1 = 1;
        drive(s);

        s = idle(); s.br = 1; s.mr = 1; s.rd = 4; s.rs1 = 4; s.u1 = 1;
        drive(s);
        drive(idle());

        s = idle(); s.dreq = 1;
        repeat (3) drive(s);
        s.drdy = 1;
        drive(s);
        drive(idle());

        s = idle(); s.drdy = 1;
        drive(s);

        s = idle(); s.dreq = 1; s.br = 1;
        repeat (2) drive(s);
        s.drdy = 1;
        drive(s);
        drive(idle());

        s = idle(); s.dreq = 1;
        repeat (8) drive(s);
        s.drdy = 1;
        drive(s);
        s.rst = 0; s.drdy = 0; s.mr = 1; s.rd = 2; s.rs1 = 2; s.u1 = 1;
        drive(s);
        drive(idle());

        s = idle(); s.rst = 0;
        drive(s);
        s = idle(); s.mr = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
        repeat (22) drive(s);
        s.mr = 0;
        drive(s);

        repeat (400) begin
            s      = idle();
            s.rs1  = 5'($urandom_range(0, 3));
            s.rs2  = 5'($urandom_range(0, 3));
            s.rd   = 5'($urandom_range(0, 3));
            s.u1   = ($urandom_range(0, 1) == 1);
            s.u2   = ($urandom_range(0, 1) == 1);
            s.mr   = ($urandom_range(0, 9) < 4);
            s.br   = ($urandom_range(0, 9) < 2);
            s.dreq = ($urandom_range(0, 3) == 0);
            s.drdy = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 29) == 0) s.rst = 1'b0;
            drive(s);
        end

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Merges three events into one coherent set of per-stage write-enable, bubble and flush controls:
  - load-use hazards detected in ID;
  - taken branches/jumps resolved in EX;
  - multi-cycle data-memory accesses in MEM (req/ready handshake).
- Adds a memory-wait watchdog and performance counters for stall and flush cycles.

Parameters:
- XLEN_CNT, 32, width of the stall and flush performance counters.
- MEM_TIMEOUT, 255, maximum number of consecutive MEM_WAIT cycles before entering TIMEOUT.
- TMR_W, 8, width of the wait timer; must satisfy 2^TMR_W > MEM_TIMEOUT.

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  rs1 index of the instruction in ID.
- id_rs2  in  5  rs2 index of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  rd of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  EX redirects the PC (taken branch, jal, jalr).
- mem_dreq  in  1  MEM instruction is accessing data memory this cycle.
- mem_dready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- ex_mem_write  out  1  EX/MEM register enable.
- id_ex_bubble  out  1  select NOP control bits into ID/EX.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  clear ID/EX to NOP.
- mem_wb_bubble  out  1  insert NOP into MEM/WB.
- timeout_err  out  1  sticky watchdog error.
- stall_cycles  out  XLEN_CNT  count of cycles with pc_write=0.
- flush_cycles  out  XLEN_CNT  count of cycles with if_id_flush=1.

Behaviour:
- FSM states: RUN, MEM_WAIT, TIMEOUT. Reset puts the FSM in RUN, clears the timer and both counters, and sets timeout_err=0.
- Control outputs are combinational from the current state and inputs, with zero added latency.
- With no event active, the write enables are 1 and the bubble/flush outputs are 0. This is also the value immediately after reset, while rst_n=0 and idle.
- Load-use hazard: luse = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
- MEM wait: mwait = mem_dreq & !mem_dready.
- Priority in RUN is mwait > ex_branch_taken > luse:
  - mwait: pc_write, if_id_write, id_ex_write and ex_mem_write all =0; mem_wb_bubble=1; next state MEM_WAIT; timer loads 1.
  - ex_branch_taken (no mwait): if_id_flush=1 and id_ex_flush=1; pc_write=1 so the redirect loads. Any simultaneous luse is discarded, because the ID instruction is being flushed.
  - luse alone: pc_write=0, if_id_write=0, id_ex_bubble=1. This lasts exactly one cycle because the load advances to MEM.
- MEM_WAIT:
  - Same freeze outputs as mwait in RUN; branch and luse are ignored.
  - On mem_dready=1: outputs revert to RUN evaluation in that same cycle and the next state is RUN. A branch already held in EX is then serviced in that cycle.
  - Otherwise the timer increments. When the timer reaches MEM_TIMEOUT, the next state is TIMEOUT.
- TIMEOUT:
  - Full freeze as in MEM_WAIT, with mem_wb_bubble=1.
  - timeout_err=1.
  - The FSM exits only by reset.
- Counters:
  - stall_cycles increments on each cycle where pc_write=0.
  - flush_cycles increments on each cycle where if_id_flush=1.
  - Both saturate at all-ones; neither wraps.
- mem_dready without mem_dreq in RUN is ignored.
- rst_n asserting mid-stall clears all state immediately; the outputs return to their idle value asynchronously.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, TIMEOUT);
  - the constant REG_X0 = 5'd0.
- Sub-module sat_counter (parameter W, inc input, async active-low reset) is instantiated twice, for stall_cycles and flush_cycles.
- The hazard compare stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1 that cycle; stall_cycles=1 afterwards.
- x0 and rs2 coverage: ex_rd=0 with id_rs1=0 -> no stall. ex_rd=7 with id_rs2=7 but id_use_rs2=0 -> no stall.
- Branch plus load-use together: ex_branch_taken=1 and luse=1 -> if_id_flush=1, id_ex_flush=1, pc_write=1, id_ex_bubble=0; flush_cycles increments by 1.
- Memory wait: mem_dreq=1, mem_dready=0 for 3 cycles, then ready -> 3 frozen cycles with mem_wb_bubble=1, state returns to RUN, stall_cycles=3.
- Watchdog: MEM_TIMEOUT=4 with mem_dready held at 0 -> TIMEOUT after 4 wait cycles, timeout_err=1 stays set; rst_n low clears it to 0 asynchronously.
- Saturation: XLEN_CNT=4 with 20 luse cycles -> stall_cycles=15 and holds at 15.
